pipe_fetch_stage: RTL and testbench
===================================

// Module: pipe_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
//  Owns the PC, drives the instruction-memory address and captures instruction + PC+4 into IF/ID.
//  Feeds the decode stage directly downstream; takes stall from the hazard unit and redirects (beq/bne/j/jal/jr) resolved in ID.
//  No branch delay slot: the wrong-path fetch is squashed.
// PARAMETERS
//  NOP_INSTR  32'h0000_0000  encoding loaded into IF/ID instr on a bubble
//  CNT_W      16             width of the fetch/bubble performance counters
// PORTS
//  CLK           in   1      clock, rising-edge
//  Reset_L       in   1      asynchronous, active-low reset
//  startPC       in   32     first fetch address, sampled on the BOOT cycle
//  iMemAddr      out  32     instruction memory address, bits[1:0] always 00
//  iMemData      in   32     instruction at iMemAddr, combinational, same cycle
//  stall         in   1      hold PC and IF/ID (load-use / jr operand hazard)
//  redirect      in   1      ID resolved a taken branch or jump; redirectPC valid
//  redirectPC    in   32     target address; bits[1:0] ignored
//  ifid_instr    out  32     registered instruction to decode
//  ifid_pcPlus4  out  32     registered PC+4 (jal link value, branch base)
//  ifid_valid    out  1      1 = real instruction, 0 = bubble
//  fetchCount    out  CNT_W  valid instructions loaded into IF/ID, saturating
//  bubbleCount   out  CNT_W  squash bubbles inserted, saturating
// BEHAVIOUR
//  Reset (Reset_L=0, async) values:
//   - state=BOOT, PC=0
//   - ifid_instr=NOP_INSTR, ifid_pcPlus4=0, ifid_valid=0
//   - fetchCount=0, bubbleCount=0
//  iMemAddr = {PC[31:2],2'b00}. In BOOT it is {startPC[31:2],2'b00}.
//  BOOT, first edge after reset release:
//   - PC<={startPC[31:2],2'b00}, state<=RUN
//   - IF/ID stays bubble; counters unchanged
//  RUN, per rising edge, highest priority first:
//   1. redirect=1 (wins over stall):
//      - PC<={redirectPC[31:2],2'b00}
//      - IF/ID<=bubble (NOP_INSTR, valid=0, pcPlus4=0)
//      - bubbleCount++
//   2. stall=1:
//      - PC, IF/ID and counters hold
//   3. else:
//      - PC<=PC+4
//      - ifid_instr<=iMemData, ifid_pcPlus4<=PC+4, ifid_valid<=1
//      - fetchCount++
//  Latency:
//   - first valid instruction (addr startPC) appears on IF/ID after the 2nd rising edge post-reset
//   - redirect costs exactly 1 bubble
//  Arithmetic:
//   - PC+4 is modulo 2^32 (0xFFFFFFFC -> 0x00000000)
//   - counters saturate at all-ones, never wrap
//  Reset mid-operation aborts immediately to BOOT; a new startPC takes effect on the BOOT edge.
//  redirect and stall only act in RUN; both are ignored in BOOT.
// STRUCTURE
//  Shared package (mips_pkg): NOP_INSTR, fetch state enum {BOOT,RUN}, 32-bit word/address widths.
//  One natural sub-module: sat_counter (CNT_W, inc, async clear), instantiated twice.
//  PC register, state flop and IF/ID register stay in this module.
// TESTING
//  T1 startPC=0x60, reset pulse, no stall:
//     - edge1 BOOT, iMemAddr=0x60
//     - edge2 ifid_pcPlus4=0x64, valid=1, instr=mem[0x60]
//     - edge3 pcPlus4=0x68
//  T2 stall=1 for 2 cycles in RUN:
//     - PC, ifid_* and fetchCount unchanged
//     - on release, fetch resumes at the held PC with no skip or duplicate
//  T3 redirect=1, redirectPC=0x19C (jal/jr):
//     - next edge valid=0, instr=NOP, bubbleCount=1
//     - following edge pcPlus4=0x1A0
//  T4 stall=1 and redirect=1 together, redirectPC=0x183:
//     - redirect wins, iMemAddr=0x180, bubble inserted
//  T5 PC forced to 0xFFFFFFFC:
//     - ifid_pcPlus4=0, next iMemAddr=0
//  T6 Reset_L low mid-run (asynchronous):
//     - outputs clear without a clock edge
//     - with CNT_W=4, 20 fetches leave fetchCount at 0xF (saturated)

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the pipelined MIPS core
//
// Purpose: word/address widths, the bubble encoding and the fetch-stage
//          state enum used across the core.
// Ports:   none (package).

package mips_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  // sll $0,$0,0 -- architecturally a no-op, used to fill pipeline bubbles
  localparam logic [WORD_W-1:0] NOP_ENCODING = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Force word alignment on any byte address
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous clear
//
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low clear
//   inc    in   1      add one this cycle (ignored once saturated)
//   count  out  CNT_W  current count

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_fetch_stage.sv
// rtl/pipe_fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose: owns the PC, addresses instruction memory and loads the fetched
//          instruction plus PC+4 into IF/ID. Redirects from ID squash the
//          wrong-path fetch with a single bubble; stall freezes PC and IF/ID.
// Ports:
//   CLK           in   1      rising-edge clock
//   Reset_L       in   1      asynchronous active-low reset
//   startPC       in   32     first fetch address, taken on the BOOT edge
//   iMemAddr      out  32     instruction memory address (word aligned)
//   iMemData      in   32     instruction at iMemAddr, same cycle
//   stall         in   1      hold PC and IF/ID
//   redirect      in   1      taken branch/jump resolved in ID
//   redirectPC    in   32     redirect target (bits[1:0] ignored)
//   ifid_instr    out  32     instruction to decode
//   ifid_pcPlus4  out  32     PC+4 of that instruction
//   ifid_valid    out  1      1 = real instruction, 0 = bubble
//   fetchCount    out  CNT_W  valid instructions loaded, saturating
//   bubbleCount   out  CNT_W  squash bubbles inserted, saturating

module pipe_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [31:0]      startPC,
  output logic [31:0]      iMemAddr,
  input  logic [31:0]      iMemData,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirectPC,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pcPlus4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetchCount,
  output logic [CNT_W-1:0] bubbleCount
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  instr_d, pcplus4_d;
  logic         valid_d;
  logic         fetch_inc, bubble_inc;

  // Low address bits are discarded by alignment
  logic unused_low_bits;
  assign unused_low_bits = ^{startPC[1:0], redirectPC[1:0]};

  // Wraps modulo 2^32 naturally
  assign pc_plus4 = pc_q + 32'd4;

  // In BOOT the PC is not loaded yet, so present startPC directly
  assign iMemAddr = (state_q == BOOT) ? word_align(startPC) : word_align(pc_q);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= BOOT;
      pc_q         <= '0;
      ifid_instr   <= NOP_INSTR;
      ifid_pcPlus4 <= '0;
      ifid_valid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr   <= instr_d;
      ifid_pcPlus4 <= pcplus4_d;
      ifid_valid   <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = ifid_instr;
    pcplus4_d  = ifid_pcPlus4;
    valid_d    = ifid_valid;
    fetch_inc  = 1'b0;
    bubble_inc = 1'b0;

    unique case (state_q)
      BOOT: begin
        // stall/redirect are meaningless before the first fetch
        pc_d    = word_align(startPC);
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Redirect beats stall: the instruction in IF is wrong-path anyway
          pc_d       = word_align(redirectPC);
          instr_d    = NOP_INSTR;
          pcplus4_d  = '0;
          valid_d    = 1'b0;
          bubble_inc = 1'b1;
        end else if (!stall) begin
          pc_d      = pc_plus4;
          instr_d   = iMemData;
          pcplus4_d = pc_plus4;
          valid_d   = 1'b1;
          fetch_inc = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (CLK),
    .rst_n (Reset_L),
    .inc   (fetch_inc),
    .count (fetchCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (CLK),
    .rst_n (Reset_L),
    .inc   (bubble_inc),
    .count (bubbleCount)
  );

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// tb/tb_pipe_fetch_stage.sv - directed self-checking bench for pipe_fetch_stage

module tb_pipe_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_data;
  logic [31:0] ifid_instr, ifid_pcplus4;
  logic        ifid_valid;
  logic [15:0] fetch_count, bubble_count;

  logic [31:0] imem_addr4, imem_data4;
  logic [31:0] ifid_instr4, ifid_pcplus4_4;
  logic        ifid_valid4;
  logic [3:0]  fetch_count4, bubble_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  assign imem_data  = mem(imem_addr);
  assign imem_data4 = mem(imem_addr4);

  pipe_fetch_stage dut (
    .CLK          (clk),
    .Reset_L      (reset_l),
    .startPC      (start_pc),
    .iMemAddr     (imem_addr),
    .iMemData     (imem_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPC   (redirect_pc),
    .ifid_instr   (ifid_instr),
    .ifid_pcPlus4 (ifid_pcplus4),
    .ifid_valid   (ifid_valid),
    .fetchCount   (fetch_count),
    .bubbleCount  (bubble_count)
  );

  pipe_fetch_stage #(.CNT_W(4)) dut4 (
    .CLK          (clk),
    .Reset_L      (reset_l),
    .startPC      (start_pc),
    .iMemAddr     (imem_addr4),
    .iMemData     (imem_data4),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPC   (redirect_pc),
    .ifid_instr   (ifid_instr4),
    .ifid_pcPlus4 (ifid_pcplus4_4),
    .ifid_valid   (ifid_valid4),
    .fetchCount   (fetch_count4),
    .bubbleCount  (bubble_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l     = 1'b0;
    start_pc    = 32'h60;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_instr",  ifid_instr, 32'h0);
    chk("rst_pcp4",   ifid_pcplus4, 32'h0);
    chk("rst_valid",  {31'b0, ifid_valid}, 32'h0);
    chk("rst_fcnt",   {16'b0, fetch_count}, 32'h0);
    chk("rst_bcnt",   {16'b0, bubble_count}, 32'h0);
    chk("rst_addr",   imem_addr, 32'h60);

    // T1: boot and first fetches
    reset_l = 1'b1;
    step();
    chk("t1_e1_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t1_e1_addr",  imem_addr, 32'h60);
    chk("t1_e1_fcnt",  {16'b0, fetch_count}, 32'h0);
    step();
    chk("t1_e2_pcp4",  ifid_pcplus4, 32'h64);
    chk("t1_e2_valid", {31'b0, ifid_valid}, 32'h1);
    chk("t1_e2_instr", ifid_instr, 32'h8C00_0060);
    chk("t1_e2_fcnt",  {16'b0, fetch_count}, 32'h1);
    step();
    chk("t1_e3_pcp4",  ifid_pcplus4, 32'h68);
    chk("t1_e3_instr", ifid_instr, 32'h8C00_0064);
    chk("t1_e3_addr",  imem_addr, 32'h68);

    // T2: two stall cycles then resume
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_hold_pcp4",  ifid_pcplus4, 32'h68);
      chk("t2_hold_instr", ifid_instr, 32'h8C00_0064);
      chk("t2_hold_addr",  imem_addr, 32'h68);
      chk("t2_hold_fcnt",  {16'b0, fetch_count}, 32'h2);
    end
    stall = 1'b0;
    step();
    chk("t2_res_pcp4",  ifid_pcplus4, 32'h6C);
    chk("t2_res_instr", ifid_instr, 32'h8C00_0068);
    chk("t2_res_fcnt",  {16'b0, fetch_count}, 32'h3);

    // T3: redirect to 0x19C
    redirect    = 1'b1;
    redirect_pc = 32'h19C;
    step();
    chk("t3_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t3_instr", ifid_instr, 32'h0);
    chk("t3_pcp4",  ifid_pcplus4, 32'h0);
    chk("t3_bcnt",  {16'b0, bubble_count}, 32'h1);
    chk("t3_addr",  imem_addr, 32'h19C);
    chk("t3_fcnt",  {16'b0, fetch_count}, 32'h3);
    redirect = 1'b0;
    step();
    chk("t3_next_pcp4",  ifid_pcplus4, 32'h1A0);
    chk("t3_next_instr", ifid_instr, 32'h8C00_019C);
    chk("t3_next_valid", {31'b0, ifid_valid}, 32'h1);

    // T4: stall and redirect together, misaligned target
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h183;
    step();
    chk("t4_addr",  imem_addr, 32'h180);
    chk("t4_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t4_bcnt",  {16'b0, bubble_count}, 32'h2);
    chk("t4_fcnt",  {16'b0, fetch_count}, 32'h4);
    redirect = 1'b0;
    step();
    chk("t4_stall_addr",  imem_addr, 32'h180);
    chk("t4_stall_valid", {31'b0, ifid_valid}, 32'h0);
    stall = 1'b0;
    step();
    chk("t4_res_pcp4", ifid_pcplus4, 32'h184);
    chk("t4_res_fcnt", {16'b0, fetch_count}, 32'h5);

    // T5: PC wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_bcnt", {16'b0, bubble_count}, 32'h3);
    redirect = 1'b0;
    step();
    chk("t5_pcp4",  ifid_pcplus4, 32'h0);
    chk("t5_instr", ifid_instr, 32'h73FF_FFFC);
    chk("t5_valid", {31'b0, ifid_valid}, 32'h1);
    chk("t5_addr0", imem_addr, 32'h0);
    chk("t5_fcnt",  {16'b0, fetch_count}, 32'h6);

    // T6: drive 14 more fetches (20 total), 4-bit counter saturates
    for (int i = 0; i < 14; i++) step();
    chk("t6_fcnt16", {16'b0, fetch_count}, 32'd20);
    chk("t6_fcnt4",  {28'b0, fetch_count4}, 32'hF);
    chk("t6_bcnt4",  {28'b0, bubble_count4}, 32'h3);
    chk("t6_pcp4",   ifid_pcplus4, 32'h38);

    // Asynchronous reset mid-cycle, no clock edge before checking
    #2;
    reset_l  = 1'b0;
    start_pc = 32'h202;
    #1;
    chk("t6_ar_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t6_ar_instr", ifid_instr, 32'h0);
    chk("t6_ar_pcp4",  ifid_pcplus4, 32'h0);
    chk("t6_ar_fcnt",  {16'b0, fetch_count}, 32'h0);
    chk("t6_ar_bcnt",  {16'b0, bubble_count}, 32'h0);
    chk("t6_ar_fcnt4", {28'b0, fetch_count4}, 32'h0);
    chk("t6_ar_addr",  imem_addr, 32'h200);

    // Re-boot with stall/redirect asserted on the BOOT edge: both ignored
    step();
    reset_l     = 1'b1;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    step();
    chk("boot_ign_addr", imem_addr, 32'h200);
    chk("boot_ign_bcnt", {16'b0, bubble_count}, 32'h0);
    chk("boot_ign_valid", {31'b0, ifid_valid}, 32'h0);
    stall    = 1'b0;
    redirect = 1'b0;
    step();
    chk("reboot_pcp4",  ifid_pcplus4, 32'h204);
    chk("reboot_instr", ifid_instr, 32'h8C00_0200);
    chk("reboot_fcnt",  {16'b0, fetch_count}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
